// File: rtl/seq_restoring_div_pkg.sv
// Shared arithmetic-path definitions: divider state encoding and default operand widths
// common to the multiplier and the restoring divider.
package seq_restoring_div_pkg;

    localparam int DW_DEF = 9;
    localparam int VW_DEF = 5;

    // Fill bit for the divide-by-zero quotient: every quotient bit is set.
    localparam logic DIV_ZERO_Q_BIT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_restoring_div_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep or restore the result.
module div_step #(
    parameter int VW = 5
) (
    input  logic [VW:0]   i_prem,
    input  logic          i_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW:0]   o_prem,
    output logic          o_qbit
);

    logic [VW+1:0] w_shift;
    logic [VW:0]   w_diff;
    logic          w_ge;

    assign w_shift = {i_prem, i_bit};
    assign w_ge    = (w_shift >= {2'b00, i_divisor});
    // The kept remainder is always below the divisor, so the trial fits in VW+1 bits.
    assign w_diff  = w_shift[VW:0] - {1'b0, i_divisor};

    assign o_qbit  = w_ge;
    assign o_prem  = w_ge ? w_diff : w_shift[VW:0];

endmodule

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider, one quotient bit per clock, with valid/ready handshakes
// on both the operand and the result side.
module seq_restoring_div
    import seq_restoring_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    div_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_shift;
    logic [VW-1:0] r_divisor;
    logic [VW:0]   r_prem;
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_div_zero;

    logic [VW:0]   w_prem;
    logic          w_qbit;

    div_step #(.VW(VW)) u_step (
        .i_prem    (r_prem),
        .i_bit     (r_shift[DW-1]),
        .i_divisor (r_divisor),
        .o_prem    (w_prem),
        .o_qbit    (w_qbit)
    );

    // r_shift doubles as dividend and quotient: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_prem      <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift   <= dividend;
                        r_divisor <= divisor;
                        r_prem    <= '0;
                        r_cnt     <= CW'(DW - 1);
                        if (divisor == '0) begin
                            r_quotient  <= {DW{DIV_ZERO_Q_BIT}};
                            r_remainder <= '0;
                            r_div_zero  <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_shift <= {r_shift[DW-2:0], w_qbit};
                    r_prem  <= w_prem;
                    if (r_cnt == '0) begin
                        r_quotient  <= {r_shift[DW-2:0], w_qbit};
                        r_remainder <= w_prem[VW-1:0];
                        r_div_zero  <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: doc/seq_restoring_div.md
Name: seq_restoring_div

Overview:
- Sequential restoring divider: the inverse of the pipelined parallel multiplier.
- Accepts a DW-bit dividend (a multiplier product) and a VW-bit divisor. Returns quotient and remainder.
- Iterates one quotient bit per clock.
- Valid/ready handshakes on both input and output, so it can sit directly downstream of the multiplier result register in the arithmetic test path.

Parameters:
- DW, 9: dividend and quotient width (matches multiplier product width).
- VW, 5: divisor and remainder width (matches multiplicand width).
- CW, 4: iteration counter width; must satisfy 2^CW >= DW.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 clears all state immediately, independent of clk.
- in_valid  in  1  dividend/divisor present.
- in_ready  out  1  block can accept an operation.
- dividend  in  DW  numerator, unsigned.
- divisor  in  VW  denominator, unsigned.
- out_valid  out  1  result held and valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  DW  unsigned quotient.
- remainder  out  VW  unsigned remainder, always < divisor when divisor != 0.
- div_zero  out  1  result came from divisor == 0.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; out_valid=0; quotient=0; remainder=0; div_zero=0; counter=0.
  - in_ready=1 (IDLE), but inputs are ignored while rst=0.
- States: IDLE, BUSY, DONE (2-bit encoding).
- in_ready = (state==IDLE). out_valid = (state==DONE). Both derive from registered state only.
- IDLE, on a rising edge with in_valid=1:
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (VW+1 bits) and set counter=DW-1.
  - divisor != 0 -> BUSY.
  - divisor == 0 -> DONE, with quotient = all ones, remainder = 0, div_zero = 1.
- BUSY, each cycle:
  - Shift the dividend MSB into the partial remainder and trial-subtract the divisor.
  - Non-negative result: keep the difference, shift a 1 into the quotient.
  - Negative result: restore the partial remainder, shift in a 0.
  - Arithmetic is unsigned and zero-extended; the trial subtract is VW+1 bits wide.
- BUSY exit: in the cycle where counter==0, complete the final bit, load the quotient/remainder output registers, clear div_zero, go to DONE. Otherwise decrement the counter.
- Latency:
  - Operation accepted at edge E0; out_valid=1 after edge E0+DW (9 cycles by default).
  - Divide-by-zero: out_valid=1 after edge E0+1.
- DONE:
  - quotient, remainder and div_zero are held stable while out_ready=0 (backpressure, unbounded).
  - On an edge with out_ready=1 -> IDLE.
  - in_ready is 0 in that same cycle, so there is no same-cycle result-pop plus new accept. Minimum operation period is DW+2 cycles.
  - Outputs keep their last values in IDLE/BUSY; only out_valid gates their meaning.
- Inputs during BUSY/DONE are ignored. The upstream must hold in_valid until in_ready.
- Reset mid-operation (BUSY or DONE): everything is cleared at once, the in-flight result is lost and no out_valid pulse is produced.
- Boundary values:
  - dividend=0 -> quotient 0, remainder 0 after the full DW cycles (no early exit).
  - dividend < divisor -> quotient 0, remainder = dividend.
  - divisor=1 -> quotient = dividend.
- Invariant when div_zero=0: quotient*divisor + remainder == dividend.

Decomposition:
- Shared arith package:
  - state encoding constants (S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2);
  - default widths DW=9 and VW=5, shared with the multiplier;
  - the DIV_ZERO quotient value (all ones).
- One natural sub-module: div_step. Purely combinational, it takes the partial remainder, the incoming bit and the divisor, and returns the next partial remainder and the quotient bit. The top holds the FSM, counter, registers and handshake.

Test Plan:
- Reset low for 2 cycles, release, dividend=180, divisor=9, in_valid=1 for one accepted cycle, out_ready=1 -> out_valid exactly 9 cycles after accept; quotient=20, remainder=0, div_zero=0.
- Back-to-back ops 150/10, 247/13, 45/15, 511/1 -> quotients 15, 19, 3, 511; all remainders 0; accepts spaced by >=11 cycles.
- Non-exact ops 200/7 and 3/31 -> 28 r4, and 0 r3.
- dividend=100, divisor=0 -> out_valid 1 cycle after accept; quotient=511, remainder=0, div_zero=1.
- 247/13 with out_ready=0 for 20 cycles -> out_valid stays 1 and outputs are stable. A new in_valid during the hold is not accepted (in_ready=0). With out_ready=1, return to IDLE next edge.
- Start 180/9, assert rst=0 asynchronously (mid-cycle) on the 4th BUSY cycle -> out_valid and outputs clear immediately. After release, in_ready=1 and no stale result appears. A new 45/15 yields 3 r0.
